pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
//  Sequences the EX/MEM-stage data-memory handshake and freezes the pipe while an access is pending.
//  Inserts a bubble on load-use hazards and squashes wrong-path instructions on a taken branch/jump.
//  Sits beside the pipeline registers; its outputs drive their stall (hold) and flush (clear to NOP) inputs.
// PARAMETERS
//  XREG_ADDRWIDTH  5   register-file address width
//  TIMEOUT_CYCLES  64  max cycles in MEM_WAIT before an access is abandoned (>=2)
// PORTS
//  clk            in   1   pipeline clock, all state on posedge
//  rst            in   1   asynchronous reset, active-high
//  id_rs1_addr    in   5   rs1 of the instruction in ID
//  id_rs2_addr    in   5   rs2 of the instruction in ID
//  id_rs1_used    in   1   ID instruction reads rs1
//  id_rs2_used    in   1   ID instruction reads rs2
//  ex_load_flag   in   5   load type of the instruction in EX; 5'b0 = no load
//  ex_rd_addr     in   5   destination of the EX instruction
//  ex_rd_en       in   1   EX instruction writes rd
//  branch_taken   in   1   EX resolved a taken branch/jump this cycle
//  mem_load_flag  in   5   load type held in EX/MEM; 5'b0 = no load
//  mem_store_flag in   3   store type held in EX/MEM; 3'b0 = no store
//  dmem_ack       in   1   data memory completes the current request this cycle
//  dmem_req       out  1   data memory request valid
//  stall_pc       out  1   hold PC
//  stall_if_id    out  1   hold IF/ID
//  stall_id_ex    out  1   hold ID/EX
//  stall_ex_mem   out  1   hold EX/MEM
//  flush_if_id    out  1   clear IF/ID to NOP on next edge
//  flush_id_ex    out  1   clear ID/EX to NOP on next edge
//  mem_err        out  1   one-cycle pulse: access timed out and was dropped
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0. All outputs 0 while rst is high and in the first cycle after.
//  mem_op = (mem_load_flag!=0) | (mem_store_flag!=0).
//  FSM, 2 states:
//   IDLE: dmem_req=mem_op.
//    mem_op & dmem_ack: zero-wait access; no stall; stay IDLE.
//    mem_op & !dmem_ack: -> MEM_WAIT, counter=1; freeze all four stall outputs this cycle.
//   MEM_WAIT: dmem_req=1; all stalls=1 while !dmem_ack.
//    dmem_ack: stalls=0 this cycle (EX/MEM advances on the edge) -> IDLE.
//    counter==TIMEOUT_CYCLES-1 & !dmem_ack: mem_err=1 and stalls=0 this cycle;
//     dmem_req=0 from the next cycle; -> IDLE. Instruction retires with unknown load data.
//    Otherwise counter+1 (saturating width clog2(TIMEOUT_CYCLES)+1).
//  Load-use hazard (luh): ex_load_flag!=0 & ex_rd_en & ex_rd_addr!=0 &
//   ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
//   luh -> stall_pc=1, stall_if_id=1, flush_id_ex=1 for one cycle (single bubble).
//  branch_taken -> flush_if_id=1, flush_id_ex=1. No stalls from this term.
//  Priority, highest first:
//   1. memory freeze (IDLE miss or MEM_WAIT without ack): all stalls=1, all flushes=0; luh/branch ignored and re-evaluated when the freeze ends.
//   2. branch_taken: flushes only, luh suppressed (the hazarding instruction is squashed).
//   3. luh.
//  Flush and stall never both asserted on the same register.
//  Asynchronous reset mid-MEM_WAIT: return to IDLE, drop dmem_req immediately, counter=0.
//  Outputs are combinational from state and inputs; no extra latency.
// TESTING
//  Load in EX/MEM, dmem_ack same cycle -> dmem_req=1 one cycle, no stall, state stays IDLE.
//  Store in EX/MEM, ack after 3 cycles -> all stalls=1 for 3 cycles, 0 on the ack cycle, then IDLE.
//  EX lw x5; ID add x6,x5,x1 -> one cycle stall_pc=stall_if_id=flush_id_ex=1; next cycle all 0.
//  EX lw x0; ID uses x0 -> no stall.
//  branch_taken and luh in the same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0.
//  TIMEOUT_CYCLES=4, no ack -> stalls high 3 cycles; mem_err pulse on the 4th; dmem_req=0 after.
//  rst asserted during MEM_WAIT -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush controller for the IF/ID, ID/EX and EX/MEM pipeline registers.
//   Sequences the EX/MEM data-memory handshake, freezing the whole pipe while an
//   access is outstanding. It also inserts a single bubble on a load-use hazard
//   and squashes wrong-path instructions when EX resolves a taken branch/jump.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   id_rs1_addr/id_rs2_addr       source registers of the ID instruction
//   id_rs1_used/id_rs2_used       ID instruction actually reads rs1/rs2
//   ex_load_flag, ex_rd_addr,     load type / destination / write enable of the
//   ex_rd_en                      EX instruction
//   branch_taken                  EX resolved a taken branch/jump this cycle
//   mem_load_flag/mem_store_flag  access type held in EX/MEM (0 = none)
//   dmem_ack                      data memory completes the request this cycle
//   dmem_req                      data memory request valid
//   stall_pc/stall_if_id/
//   stall_id_ex/stall_ex_mem      hold the corresponding register
//   flush_if_id/flush_id_ex       clear the corresponding register to NOP
//   mem_err                       one-cycle pulse: access timed out and dropped
module pipe_hazard_ctrl #(
  parameter int unsigned XREG_ADDRWIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs1_addr,
  input  logic [XREG_ADDRWIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [4:0]                ex_load_flag,
  input  logic [XREG_ADDRWIDTH-1:0] ex_rd_addr,
  input  logic                      ex_rd_en,
  input  logic                      branch_taken,
  input  logic [4:0]                mem_load_flag,
  input  logic [2:0]                mem_store_flag,
  input  logic                      dmem_ack,
  output logic                      dmem_req,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      stall_id_ex,
  output logic                      stall_ex_mem,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      mem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Low during reset and the first cycle after release; keeps every output
  // quiet and the FSM parked until the pipeline registers have settled.
  logic             ready_q;

  logic active;
  logic mem_op;
  logic luh;
  logic freeze;

  assign active = ready_q & ~rst;
  assign mem_op = (mem_load_flag != '0) | (mem_store_flag != '0);

  assign luh = (ex_load_flag != '0) & ex_rd_en & (ex_rd_addr != '0) &
               ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freeze       = 1'b0;
    dmem_req     = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    mem_err      = 1'b0;

    if (active) begin
      unique case (state_q)
        IDLE: begin
          dmem_req = mem_op;
          if (mem_op && !dmem_ack) begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
            freeze  = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            // Abandon the access: release the pipe so the instruction retires.
            mem_err = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            freeze = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // A memory freeze overrides everything; a taken branch squashes the
      // instruction that would have caused the load-use bubble.
      if (freeze) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (branch_taken) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (luh) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT_CYCLES = 4).
// Output vector order: {dmem_req, stall_pc, stall_if_id, stall_id_ex,
//                       stall_ex_mem, flush_if_id, flush_id_ex, mem_err}
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_addr, id_rs2_addr;
  logic       id_rs1_used, id_rs2_used;
  logic [4:0] ex_load_flag, ex_rd_addr;
  logic       ex_rd_en, branch_taken;
  logic [4:0] mem_load_flag;
  logic [2:0] mem_store_flag;
  logic       dmem_ack;
  logic       dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       flush_if_id, flush_id_ex, mem_err;
  logic [7:0] outv;

  int checks = 0;
  int errors = 0;

  // Reference model: whether an access is outstanding and how many cycles of
  // it have already elapsed (the miss cycle counts as the first).
  bit m_active = 1'b0;
  bit m_wait   = 1'b0;
  int m_elapsed = 0;

  pipe_hazard_ctrl #(.XREG_ADDRWIDTH(5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_load_flag(ex_load_flag), .ex_rd_addr(ex_rd_addr), .ex_rd_en(ex_rd_en),
    .branch_taken(branch_taken),
    .mem_load_flag(mem_load_flag), .mem_store_flag(mem_store_flag),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .mem_err(mem_err)
  );

  assign outv = {dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                 flush_if_id, flush_id_ex, mem_err};

  always #5 clk = ~clk;

  function automatic bit mem_busy();
    return (mem_load_flag != 0) || (mem_store_flag != 0);
  endfunction

  function automatic bit timed_out();
    return m_wait && !dmem_ack && (m_elapsed == TMO - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  <= 1'b0;
      m_wait    <= 1'b0;
      m_elapsed <= 0;
    end else if (!m_active) begin
      m_active <= 1'b1;
    end else if (!m_wait) begin
      if (mem_busy() && !dmem_ack) begin
        m_wait    <= 1'b1;
        m_elapsed <= 1;
      end
    end else if (dmem_ack || timed_out()) begin
      m_wait    <= 1'b0;
      m_elapsed <= 0;
    end else begin
      m_elapsed <= m_elapsed + 1;
    end
  end

  function automatic logic [7:0] exp_out();
    logic [7:0] e;
    bit frz, hz, reads_rd;
    e = '0;
    if (rst || !m_active) return e;
    reads_rd = (id_rs1_used && id_rs1_addr == ex_rd_addr) ||
               (id_rs2_used && id_rs2_addr == ex_rd_addr);
    hz  = (ex_load_flag != 0) && ex_rd_en && (ex_rd_addr != 0) && reads_rd;
    frz = !dmem_ack && (m_wait ? !timed_out() : mem_busy());
    e[7] = m_wait ? 1'b1 : mem_busy();
    e[0] = timed_out();
    if (frz)               e[6:3] = 4'hF;
    else if (branch_taken) e[2:1] = 2'b11;
    else if (hz) begin
      e[6] = 1'b1; e[5] = 1'b1; e[1] = 1'b1;
    end
    return e;
  endfunction

  task automatic clear_in();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_load_flag = '0; ex_rd_addr = '0; ex_rd_en = 1'b0; branch_taken = 1'b0;
    mem_load_flag = '0; mem_store_flag = '0; dmem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clear_in();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    mem_store_flag = 3'd2;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL reset_hold got %b exp %b", outv, 8'h00); end
    @(negedge clk);
    rst = 1'b0;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL reset_first_cycle got %b exp %b", outv, 8'h00); end
    next_cycle();
    mem_store_flag = 3'd2;
    #1; checks++;
    if (outv !== 8'b1111_1000) begin errors++; $display("FAIL reset_then_miss got %b exp %b", outv, 8'b1111_1000); end
    next_cycle();
    mem_store_flag = 3'd2; dmem_ack = 1'b1;
    #1; checks++;
    if (outv !== 8'b1000_0000) begin errors++; $display("FAIL reset_then_ack got %b exp %b", outv, 8'b1000_0000); end
    next_cycle();
  endtask

  task automatic test_zero_wait_load();
    next_cycle();
    mem_load_flag = 5'd3; dmem_ack = 1'b1;
    #1; checks++;
    if (outv !== 8'b1000_0000) begin errors++; $display("FAIL zero_wait got %b exp %b", outv, 8'b1000_0000); end
    next_cycle();
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL zero_wait_after got %b exp %b", outv, 8'h00); end
  endtask

  task automatic test_store_wait();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_store_flag = 3'd1;
      if (i == 1) begin  // a load-use hazard during the freeze is ignored
        ex_load_flag = 5'd1; ex_rd_en = 1'b1; ex_rd_addr = 5'd7;
        id_rs1_used = 1'b1; id_rs1_addr = 5'd7;
      end
      #1; checks++;
      if (outv !== 8'b1111_1000) begin errors++; $display("FAIL store_wait%0d got %b exp %b", i, outv, 8'b1111_1000); end
    end
    next_cycle();
    mem_store_flag = 3'd1; dmem_ack = 1'b1;
    #1; checks++;
    if (outv !== 8'b1000_0000) begin errors++; $display("FAIL store_ack got %b exp %b", outv, 8'b1000_0000); end
    next_cycle();
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL store_idle got %b exp %b", outv, 8'h00); end
  endtask

  task automatic test_load_use();
    next_cycle();
    ex_load_flag = 5'd1; ex_rd_en = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd5; id_rs2_used = 1'b1; id_rs2_addr = 5'd1;
    #1; checks++;
    if (outv !== 8'b0110_0010) begin errors++; $display("FAIL luh got %b exp %b", outv, 8'b0110_0010); end
    next_cycle();  // bubble now in EX, add still in ID
    id_rs1_used = 1'b1; id_rs1_addr = 5'd5; id_rs2_used = 1'b1; id_rs2_addr = 5'd1;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL luh_after got %b exp %b", outv, 8'h00); end
    next_cycle();
    ex_load_flag = 5'd1; ex_rd_en = 1'b1; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b1; id_rs1_addr = 5'd0;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL luh_x0 got %b exp %b", outv, 8'h00); end
  endtask

  task automatic test_branch_luh();
    next_cycle();
    ex_load_flag = 5'd2; ex_rd_en = 1'b1; ex_rd_addr = 5'd9;
    id_rs2_used = 1'b1; id_rs2_addr = 5'd9; branch_taken = 1'b1;
    #1; checks++;
    if (outv !== 8'b0000_0110) begin errors++; $display("FAIL branch_luh got %b exp %b", outv, 8'b0000_0110); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TMO - 1; i++) begin
      next_cycle();
      mem_load_flag = 5'd4;
      #1; checks++;
      if (outv !== 8'b1111_1000) begin errors++; $display("FAIL timeout_stall%0d got %b exp %b", i, outv, 8'b1111_1000); end
    end
    next_cycle();
    mem_load_flag = 5'd4;
    #1; checks++;
    if (outv !== 8'b1000_0001) begin errors++; $display("FAIL timeout_err got %b exp %b", outv, 8'b1000_0001); end
    next_cycle();
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL timeout_after got %b exp %b", outv, 8'h00); end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_store_flag = 3'd3;
      #1; checks++;
      if (outv !== 8'b1111_1000) begin errors++; $display("FAIL midrst_wait%0d got %b exp %b", i, outv, 8'b1111_1000); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL midrst_assert got %b exp %b", outv, 8'h00); end
    @(negedge clk);
    rst = 1'b0;
    #1; checks++;
    if (outv !== 8'h00) begin errors++; $display("FAIL midrst_release got %b exp %b", outv, 8'h00); end
    next_cycle();  // restarts from IDLE: miss again, freeze with fresh timeout
    mem_store_flag = 3'd3;
    #1; checks++;
    if (outv !== 8'b1111_1000) begin errors++; $display("FAIL midrst_idle got %b exp %b", outv, 8'b1111_1000); end
    next_cycle();
    mem_store_flag = 3'd3; dmem_ack = 1'b1;
    #1; checks++;
    if (outv !== 8'b1000_0000) begin errors++; $display("FAIL midrst_ack got %b exp %b", outv, 8'b1000_0000); end
    next_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] e;
      @(negedge clk);
      rst = ($urandom_range(0, 79) == 0);
      id_rs1_addr    = 5'($urandom_range(0, 3));
      id_rs2_addr    = 5'($urandom_range(0, 3));
      id_rs1_used    = 1'($urandom_range(0, 1));
      id_rs2_used    = 1'($urandom_range(0, 1));
      ex_load_flag   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'd0;
      ex_rd_addr     = 5'($urandom_range(0, 3));
      ex_rd_en       = 1'($urandom_range(0, 1));
      branch_taken   = ($urandom_range(0, 4) == 0);
      mem_load_flag  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      mem_store_flag = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      dmem_ack       = ($urandom_range(0, 3) == 0);
      #1;
      e = exp_out();
      checks++;
      if (outv !== e) begin
        errors++;
        $display("FAIL random%0d got %b exp %b", n, outv, e);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_load_use();
    test_branch_luh();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
